// File: rtl/contador_param.sv
// Parametrised up/down counter with parallel load, optional saturation and a
// combinational carry-out so several stages can be chained into a wider counter.
module contador_param #(
   parameter int unsigned WIDTH   = 32,
   parameter int unsigned D_WIDTH = 4,
   parameter int unsigned STEP    = 3
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               enable,
   input  logic               cin,
   input  logic               sat,
   input  logic [1:0]         mode,
   input  logic [D_WIDTH-1:0] D,
   output logic [WIDTH-1:0]   Q,
   output logic               load,
   output logic               rco,
   output logic               co
);

   localparam logic [1:0] MODE_UP    = 2'b00;
   localparam logic [1:0] MODE_DOWN  = 2'b01;
   localparam logic [1:0] MODE_STEP  = 2'b10;
   localparam logic [1:0] MODE_LOAD  = 2'b11;

   localparam logic [WIDTH-1:0] MAX_VAL  = {WIDTH{1'b1}};
   localparam logic [WIDTH-1:0] ZERO_VAL = '0;
   localparam logic [WIDTH-1:0] STEP_VAL = WIDTH'(STEP);

   logic [WIDTH-1:0] q_next;
   logic             load_next;
   logic             rco_next;
   logic             bnd;

   // bnd marks a count that would cross the range limit for the current mode
   always_comb begin
      bnd = 1'b0;
      case (mode)
         MODE_UP:   bnd = (Q == MAX_VAL);
         MODE_DOWN: bnd = (Q == ZERO_VAL);
         MODE_STEP: bnd = (Q < STEP_VAL);
         default:   bnd = 1'b0;
      endcase
   end

   always_comb begin
      q_next    = Q;
      load_next = 1'b0;
      rco_next  = 1'b0;
      if (enable) begin
         if (mode == MODE_LOAD) begin
            q_next    = WIDTH'(D);
            load_next = 1'b1;
         end else if (cin) begin
            rco_next = bnd;
            case (mode)
               MODE_UP:   q_next = (bnd && sat) ? MAX_VAL  : Q + 1'b1;
               MODE_DOWN: q_next = (bnd && sat) ? ZERO_VAL : Q - 1'b1;
               MODE_STEP: q_next = (bnd && sat) ? ZERO_VAL : Q - STEP_VAL;
               default:   q_next = Q;
            endcase
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         Q    <= '0;
         load <= 1'b0;
         rco  <= 1'b0;
      end else begin
         Q    <= q_next;
         load <= load_next;
         rco  <= rco_next;
      end
   end

   // Unregistered so the next stage sees the carry in the same cycle
   assign co = enable & cin & ~sat & bnd;

endmodule

// File: doc/contador_param.md
# contador_param

Parametrised up/down counter with parallel load. It generalises the fixed 32-bit, 4-bit-load counter to arbitrary counter, load and step widths, and adds saturating operation and a combinational carry chain for cascading stages. It sits under the same driver/checker/scoreboard bench style and keeps the established mode encoding and `load`/`rco` flag semantics.

## Interface
- `WIDTH`, 32: counter width in bits; must be ≥ 2.
- `D_WIDTH`, 4: parallel-load data width; 1 ≤ D_WIDTH ≤ WIDTH.
- `STEP`, 3: decrement size for mode 10; 1 ≤ STEP ≤ 2^WIDTH−1.

Ports:
- `clk`  in  1  clock; all state updates on rising edge.
- `reset`  in  1  synchronous, active-low reset.
- `enable`  in  1  block enable; 0 = hold.
- `cin`  in  1  count permission from the lower cascade stage; tie to 1 when standalone.
- `sat`  in  1  1 = saturate at bounds, 0 = wrap.
- `mode`  in  2  00 up 1, 01 down 1, 10 down STEP, 11 load.
- `D`  in  D_WIDTH  load value, zero-extended to WIDTH.
- `Q`  out  WIDTH  counter value, registered.
- `load`  out  1  registered; high one cycle after a load executes.
- `rco`  out  1  registered ripple-carry; high one cycle after a boundary event.
- `co`  out  1  combinational carry-out for cascading.

## Operation
- MAX = 2^WIDTH−1. All arithmetic is modulo 2^WIDTH unless saturating.
- Reset (`reset`=0 at edge) has highest priority: Q=0, load=0, rco=0. `co` then follows its equation from Q=0.
- `enable`=0: Q holds; load=0, rco=0.
- `enable`=1, mode 11: Q ← {0, D}; load=1, rco=0. `cin` is ignored.
- `enable`=1, mode 00/01/10, `cin`=0: Q holds; load=0, rco=0.
- `enable`=1, `cin`=1, load=0 in all count modes:
  - Mode 00: Q<MAX: Q+1, rco=0. Q=MAX: wrap gives 0, saturate keeps MAX; rco=1.
  - Mode 01: Q>0: Q−1, rco=0. Q=0: wrap gives MAX, saturate keeps 0; rco=1.
  - Mode 10: Q≥STEP: Q−STEP, rco=0. Q<STEP: wrap gives Q−STEP mod 2^WIDTH, saturate gives 0; rco=1.
- In saturate mode, rco=1 on every counting cycle that attempts to pass the bound, including while pinned.
- Boundary condition B is Q=MAX for mode 00, Q=0 for mode 01, Q<STEP for mode 10, and false for mode 11.
- `co` = enable & cin & ~sat & B, evaluated combinationally from current Q and inputs.
- Cascade: a lower stage's `co` drives the upper stage's `cin`. Stages share `clk`, `reset`, `enable` and `mode`. Saturating cascades are unsupported.
- Mode 10 in a cascade is only meaningful for the least-significant stage. Upper stages are driven with mode 01.

## Timing
- Q, load and rco update one cycle after the sampled inputs (latency 1).
- `co` has zero-cycle latency and is valid in the same cycle as the boundary. It must not be registered.
- load and rco are single-cycle pulses, unless the triggering condition repeats on consecutive cycles.
- Reset mid-count: the next edge gives Q=0 with flags cleared. The first count acts on the edge after `reset` returns to 1.
- Mode changes take effect on the next edge with no pipeline flush. Load followed immediately by a count counts from the loaded value.
- No X on any output after the first reset edge.

## Test plan
- Reset, then mode 11 with D=4'hA, enable=1: Q=32'h0000000A and load=1 for one cycle; then mode 00 for 3 cycles gives Q=0xD, with rco never set.
- Load 0xF, then mode 00 with Q forced to MAX by cascade preload (WIDTH=8 instance, load D=8'hFF, D_WIDTH=8): next edge gives Q=0 and rco=1; `co`=1 in the cycle where Q=FF.
- WIDTH=8, sat=1, Q=FF, mode 00 for 3 cycles: Q stays FF, rco=1 on each cycle, co=0 throughout.
- Mode 10 with STEP=3 from Q=5: Q=2, then Q=0xFFFFFFFF with rco=1; repeat with sat=1: Q=2, then 0 with rco=1, then 0 with rco=1.
- Two WIDTH=4 stages cascaded, both in mode 00, counting from 0 for 20 cycles: the combined value equals 20. The upper stage increments exactly once, on the edge where the lower stage goes F→0.
- During counting at Q=0x1234, assert reset=0 for one edge: Q=0, load=0, rco=0. enable=0 holds Q with both flags low.
